// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery multiplier sharing logic:
// the arbiter state encoding, the default operand width and a small
// wrap-around helper used for round-robin pointer arithmetic.
package mont_pkg;

  // Default operand/result width of the shared Montgomery core
  localparam int MONT_WIDTH = 512;

  // Width of the watchdog cycle counter
  localparam int WDOG_W = 32;

  // Arbiter sequencing: pick a winner, issue to the core, wait, respond
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  // (base + off) modulo n, for base < n and off < n.
  // Wraps at the requester count rather than at a power of two, so
  // non power-of-two requester counts rotate correctly.
  function automatic int wrapAdd(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    if (sum >= n) begin
      sum = sum - n;
    end
    return sum;
  endfunction

endpackage

// File: rtl/mont_mult_arbiter_rr_pick.sv
// Round-robin picker: given the request vector and the rotation
// pointer, reports whether anyone is requesting and which requester
// is the first one at or above the pointer, wrapping around.
// Purely combinational so other arbiters can reuse it.
module rr_pick
  import mont_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            any_o,
  output logic [IDW-1:0]  winner_o
);

  // Scan from the farthest offset down so the nearest request to the pointer wins
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req_i[IDW'(wrapAdd(int'(ptr_i), off, NREQ))]) begin
        any_o    = 1'b1;
        winner_o = IDW'(wrapAdd(int'(ptr_i), off, NREQ));
      end
    end
  end

endmodule

// File: rtl/mont_mult_arbiter.sv
// Shares a single Montgomery multiplier among several requesters.
// A round-robin winner has its operands latched and the core started
// with a one-cycle pulse; the result and a done pulse are routed back
// to the owner. A watchdog aborts a transaction if the core never
// answers, returning a zero result flagged with err.
module mont_mult_arbiter
  import mont_pkg::*;
#(
  parameter int WIDTH   = MONT_WIDTH,
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  req_a,
  input  logic [NREQ*WIDTH-1:0]  req_b,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   err,
  output logic [WIDTH-1:0]       res,
  output logic                   busy,
  output logic [IDW-1:0]         owner,
  output logic                   mult_start,
  output logic [WIDTH-1:0]       mult_a,
  output logic [WIDTH-1:0]       mult_b,
  input  logic [WIDTH-1:0]       mult_res,
  input  logic                   mult_done
);

  // Last WAIT count before the watchdog gives up on the core
  localparam logic [WDOG_W-1:0] WDOG_LIMIT =
    (TIMEOUT == 0) ? '0 : WDOG_W'(TIMEOUT - 1);

  arb_state_t         state_q;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     owner_q;
  logic [WDOG_W-1:0]  wdog_q;
  logic [WDOG_W-1:0]  wdog_d;
  logic [NREQ-1:0]    gnt_q;
  logic [NREQ-1:0]    done_q;
  logic               err_q;
  logic               multStart_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   multA_q;
  logic [WIDTH-1:0]   multB_q;

  logic               pickAny;
  logic [IDW-1:0]     pickId;
  logic [IDW-1:0]     ptrNext;
  logic [NREQ-1:0]    pickOneHot;
  logic [NREQ-1:0]    ownerOneHot;
  logic               wdogHit;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .any_o    (pickAny),
    .winner_o (pickId)
  );

  assign ptrNext     = IDW'(wrapAdd(int'(pickId), 1, NREQ));
  assign pickOneHot  = NREQ'(1) << pickId;
  assign ownerOneHot = NREQ'(1) << owner_q;

  // Watchdog next count and expiry test; a zero TIMEOUT never expires
  always_comb begin
    wdog_d  = wdog_q + WDOG_W'(1);
    wdogHit = 1'b0;
    if (TIMEOUT != 0) begin
      wdogHit = (wdog_q == WDOG_LIMIT);
    end
  end

  // Arbiter sequencing with registered grant/start/done/err pulses
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      wdog_q      <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      multStart_q <= 1'b0;
      res_q       <= '0;
      multA_q     <= '0;
      multB_q     <= '0;
    end else begin
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      multStart_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (pickAny) begin
            multA_q     <= req_a[int'(pickId)*WIDTH +: WIDTH];
            multB_q     <= req_b[int'(pickId)*WIDTH +: WIDTH];
            owner_q     <= pickId;
            ptr_q       <= ptrNext;
            gnt_q       <= pickOneHot;
            multStart_q <= 1'b1;
            state_q     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          wdog_q  <= '0;
          state_q <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (mult_done) begin
            res_q   <= mult_res;
            done_q  <= ownerOneHot;
            state_q <= ARB_RESP;
          end else if (wdogHit) begin
            res_q   <= '0;
            done_q  <= ownerOneHot;
            err_q   <= 1'b1;
            state_q <= ARB_RESP;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign res        = res_q;
  assign busy       = (state_q != ARB_IDLE);
  assign owner      = owner_q;
  assign mult_start = multStart_q;
  assign mult_a     = multA_q;
  assign mult_b     = multB_q;

endmodule
